// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan path: digit geometry,
// anode decoding and the leading-zero blanking rule.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int NIB_W      = 4;
  localparam int WORD_W     = 16;

  typedef logic [NIB_W-1:0]      nibble_t;
  typedef logic [SEL_W-1:0]      sel_t;
  typedef logic [NUM_DIGITS-1:0] an_t;
  typedef logic [WORD_W-1:0]     word_t;

  localparam an_t AN_OFF = '1;

  // Active-low one-hot anode pattern for the selected digit.
  function automatic an_t an_decode(input sel_t sel);
    return ~(an_t'(1) << sel);
  endfunction

  // Digit s is a leading zero when it and every more-significant nibble
  // are zero. Digit 0 always shows so a zero word still reads "0".
  function automatic logic lz_blank(input word_t w, input sel_t s);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(s) && w[k*NIB_W +: NIB_W] != '0) all_zero = 1'b0;
    end
    return (s != '0) && all_zero;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Control/data bundle between the word source and the scan controller.
// master drives the word and controls; slave is the scan controller.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic    en;
  logic    load;
  word_t   data_in;
  logic    lz_en;
  nibble_t d0, d1, d2, d3;
  sel_t    sel;
  an_t     an;
  logic    frame_done;

  modport master (
    output en, load, data_in, lz_en,
    input  d0, d1, d2, d3, sel, an, frame_done
  );

  modport slave (
    input  en, load, data_in, lz_en,
    output d0, d1, d2, d3, sel, an, frame_done
  );
endinterface

// File: rtl/seg_prescaler.sv
// Slot prescaler: counts 0..TICK_DIV-1 while enabled and flags the last
// count of each slot. Holds its count while disabled.
module seg_prescaler #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick only while running so a frozen count at the top never re-fires.
  always_comb begin
    tick  = en && (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller. Latches a display word,
// swaps it in only at frame wrap (tear-free), drives the digit mux select
// and the matching active-low anodes with slot-start blanking and optional
// leading-zero suppression. All outputs come straight from flops.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  seg_prescaler #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .cnt   (cnt),
    .tick  (tick)
  );

  sel_t  sel_q, sel_d;
  word_t pend_q, pend_d;
  word_t disp_q, disp_d;
  logic  pend_v_q, pend_v_d;
  an_t   an_q, an_d;
  logic  fd_q, fd_d;
  logic  wrap;
  logic  slot_blank;

  // Next-state for select, word registers and frame pulse.
  always_comb begin
    wrap     = tick && (sel_q == sel_t'(NUM_DIGITS - 1));
    sel_d    = tick ? sel_q + sel_t'(1) : sel_q;
    pend_d   = pend_q;
    disp_d   = disp_q;
    pend_v_d = pend_v_q;
    // Swap first, then a coincident load refills pend for the next frame.
    if (wrap && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (bus.load) begin
      pend_d   = bus.data_in;
      pend_v_d = 1'b1;
    end
    fd_d = wrap;
  end

  // Anodes are computed from next-state cnt/sel/disp so the new select and
  // its first anode value land on the same edge.
  always_comb begin
    slot_blank = 1'b0;
    if (tick) slot_blank = (BLANK_CYC > 0);
    else      slot_blank = (int'(cnt) + 1) < BLANK_CYC;
    an_d = an_decode(sel_d);
    if (!bus.en || slot_blank || (bus.lz_en && lz_blank(disp_d, sel_d)))
      an_d = AN_OFF;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      pend_q   <= '0;
      disp_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      disp_q   <= disp_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.d0         = disp_q[3:0];
  assign bus.d1         = disp_q[7:4];
  assign bus.d2         = disp_q[11:8];
  assign bus.d3         = disp_q[15:12];
  assign bus.sel        = sel_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=8, BLANK_CYC=2.
// Vector table: each record holds its inputs for ncyc clock edges (load
// only on the first), then the outputs are compared. Timeline comments give
// edges since reset release: cnt = t%8, sel = (t/8)%4.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic        en, lz, ld;
    logic [15:0] data;
    int          ncyc;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic        fd;
    logic [15:0] d;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int en, int lz, int ld, int data, int n,
                              int sel, int an, int fd, int d);
    vec_t v;
    v.en = en[0]; v.lz = lz[0]; v.ld = ld[0]; v.data = data[15:0];
    v.ncyc = n; v.sel = sel[1:0]; v.an = an[3:0]; v.fd = fd[0]; v.d = d[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] dword();
    return {bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] sel, input logic [3:0] an,
                         input logic fd, input logic [15:0] d);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(sel));
    chk({tag, ".an"},  32'(bus.an),  32'(an));
    chk({tag, ".fd"},  32'(bus.frame_done), 32'(fd));
    chk({tag, ".d"},   32'(dword()), 32'(d));
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.data_in = '0; bus.lz_en = 1'b0;

    //        en lz ld data    n   sel an  fd d
    tv.push_back(mk(1, 0, 0, 'h0,    1, 0, 'hF, 0, 'h0));    // t=1
    tv.push_back(mk(1, 0, 0, 'h0,    1, 0, 'hE, 0, 'h0));    // t=2
    tv.push_back(mk(1, 0, 0, 'h0,    5, 0, 'hE, 0, 'h0));    // t=7
    tv.push_back(mk(1, 0, 0, 'h0,    1, 1, 'hF, 0, 'h0));    // t=8
    tv.push_back(mk(1, 0, 0, 'h0,    2, 1, 'hD, 0, 'h0));    // t=10
    tv.push_back(mk(1, 0, 0, 'h0,    8, 2, 'hB, 0, 'h0));    // t=18
    tv.push_back(mk(1, 0, 0, 'h0,    8, 3, 'h7, 0, 'h0));    // t=26
    tv.push_back(mk(1, 0, 0, 'h0,    6, 0, 'hF, 1, 'h0));    // t=32 wrap
    tv.push_back(mk(1, 0, 0, 'h0,    1, 0, 'hF, 0, 'h0));    // t=33
    tv.push_back(mk(1, 0, 0, 'h0,    7, 1, 'hF, 0, 'h0));    // t=40
    tv.push_back(mk(1, 0, 1, 'h12A4, 1, 1, 'hF, 0, 'h0));    // t=41 load in slot 1
    tv.push_back(mk(1, 0, 0, 'h0,   22, 3, 'h7, 0, 'h0));    // t=63 still old
    tv.push_back(mk(1, 0, 0, 'h0,    1, 0, 'hF, 1, 'h12A4)); // t=64 swap
    tv.push_back(mk(1, 0, 1, 'h1111, 1, 0, 'hF, 0, 'h12A4)); // t=65
    tv.push_back(mk(1, 0, 0, 'h0,   30, 3, 'h7, 0, 'h12A4)); // t=95 wrap-tick state
    tv.push_back(mk(1, 0, 1, 'h5555, 1, 0, 'hF, 1, 'h1111)); // t=96 load on wrap
    tv.push_back(mk(1, 0, 0, 'h0,   31, 3, 'h7, 0, 'h1111)); // t=127
    tv.push_back(mk(1, 0, 0, 'h0,    1, 0, 'hF, 1, 'h5555)); // t=128
    tv.push_back(mk(1, 1, 1, 'h0030, 1, 0, 'hF, 0, 'h5555)); // t=129
    tv.push_back(mk(1, 1, 0, 'h0,   31, 0, 'hF, 1, 'h0030)); // t=160
    tv.push_back(mk(1, 1, 0, 'h0,    2, 0, 'hE, 0, 'h0030)); // t=162
    tv.push_back(mk(1, 1, 0, 'h0,    8, 1, 'hD, 0, 'h0030)); // t=170
    tv.push_back(mk(1, 1, 0, 'h0,    8, 2, 'hF, 0, 'h0030)); // t=178 lz
    tv.push_back(mk(1, 1, 0, 'h0,    8, 3, 'hF, 0, 'h0030)); // t=186 lz
    tv.push_back(mk(1, 1, 1, 'h0000, 1, 3, 'hF, 0, 'h0030)); // t=187
    tv.push_back(mk(1, 1, 0, 'h0,    5, 0, 'hF, 1, 'h0000)); // t=192
    tv.push_back(mk(1, 1, 0, 'h0,    2, 0, 'hE, 0, 'h0000)); // t=194 digit 0 kept
    tv.push_back(mk(1, 1, 0, 'h0,    8, 1, 'hF, 0, 'h0000)); // t=202
    tv.push_back(mk(1, 1, 0, 'h0,    8, 2, 'hF, 0, 'h0000)); // t=210
    tv.push_back(mk(1, 0, 0, 'h0,    8, 3, 'h7, 0, 'h0000)); // t=218 lz off

    // Reset state.
    repeat (2) step();
    chk_out("reset", 2'd0, 4'hF, 1'b0, 16'h0);

    rst_n = 1'b1;
    foreach (tv[i]) begin
      bus.en = tv[i].en; bus.lz_en = tv[i].lz;
      bus.load = tv[i].ld; bus.data_in = tv[i].data;
      step();
      bus.load = 1'b0;
      repeat (tv[i].ncyc - 1) step();
      chk_out($sformatf("v%0d", i), tv[i].sel, tv[i].an, tv[i].fd, tv[i].d);
    end

    // Enable low at cnt=5, sel=2 (t=245), hold 20 cycles.
    repeat (27) step();
    chk("pre_dis.sel", 32'(bus.sel), 32'd2);
    chk("pre_dis.an",  32'(bus.an),  32'hB);
    bus.en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("dis%0d.an", k),  32'(bus.an),  32'hF);
      chk($sformatf("dis%0d.sel", k), 32'(bus.sel), 32'd2);
      chk($sformatf("dis%0d.fd", k),  32'(bus.frame_done), 32'd0);
    end
    // Resume from cnt=5: cnt 6, 7, then tick to sel=3.
    bus.en = 1'b1;
    step();
    chk("re1.an",  32'(bus.an),  32'hB);
    chk("re1.sel", 32'(bus.sel), 32'd2);
    step();
    chk("re2.sel", 32'(bus.sel), 32'd2);
    step();
    chk("re3.sel", 32'(bus.sel), 32'd3);
    chk("re3.an",  32'(bus.an),  32'hF);

    // Reset mid-frame with a pending word.
    bus.load = 1'b1; bus.data_in = 16'h9999;
    step();
    bus.load = 1'b0;
    repeat (3) step();
    chk("prerst.an",  32'(bus.an),  32'h7);
    chk("prerst.sel", 32'(bus.sel), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 2'd0, 4'hF, 1'b0, 16'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("post%0d.d", k), 32'(dword()), 32'h0);
      if (k == 32) begin
        chk("post32.fd",  32'(bus.frame_done), 32'd1);
        chk("post32.sel", 32'(bus.sel), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display. It sits directly upstream of the 4-to-1 × 4-bit digit mux. It latches a 16-bit display word and presents the four nibbles to the mux data inputs. It drives the mux select with a free-running digit counter and generates the matching active-low anode enables, with anti-ghosting blanking, leading-zero suppression and frame-synchronous (tear-free) updates.

## Interface
- `TICK_DIV`, 100000: clk cycles per digit slot; legal range 4..2^20.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK_CYC < TICK_DIV.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; low freezes the scan and turns the display off.
- `load`  in  1  one-cycle strobe that captures `data_in` into the pending register.
- `data_in`  in  16  display word; nibble k goes to digit k, digit 0 is rightmost.
- `lz_en`  in  1  leading-zero suppression enable.
- `d0`,`d1`,`d2`,`d3`  out  4 each  displayed nibbles, wired to mux D0..D3.
- `sel`  out  2  digit select, wired to mux S.
- `an`  out  4  anode enables, active-low.
- `frame_done`  out  1  one-cycle pulse when `sel` wraps 3→0.

## Operation
- **Prescaler.** `cnt` counts 0..TICK_DIV-1 while `en`=1. `tick` is asserted when `cnt`==TICK_DIV-1; `cnt` then returns to 0. When `en`=0, `cnt` holds.
- **Digit counter.** On `tick`, `sel` increments modulo 4 (3→0 wraps).
- **Pending register.** On `load`, `pend` takes `data_in` and `pend_v` is set to 1.
- **Displayed register.** On the wrap tick (`sel`==3 and `tick`) with `pend_v`=1, `disp` takes `pend` and `pend_v` clears. The outputs `d0..d3` are `disp[3:0]..disp[15:12]`.
- **Load coincident with wrap tick.** `disp` takes the old `pend`, `pend` takes the new `data_in`, and `pend_v` stays 1. The new word appears one frame later.
- **Multiple loads within one frame.** The last load wins.
- **Leading-zero suppression.** With `lz_en`=1, digit k (k = 3, 2, 1) is blanked when `disp` nibbles k..3 are all zero. Digit 0 is never blanked.
- **Anode output.** `an` is all ones (4'hF) when any of the following holds: `en`=0; `cnt` < BLANK_CYC; the current digit is blanked. Otherwise `an` = ~(1 << `sel`).
- **Frame pulse.** `frame_done` is 1 for exactly the cycle after the wrap tick.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Reset values:**
  - `cnt`=0, `sel`=0, `an`=4'hF, `frame_done`=0.
  - `disp`=0, so `d0..d3`=0.
  - `pend`=0, `pend_v`=0.
- `sel` and the first `an` value of a new slot update on the same clock edge, so a stale anode never coincides with a new select.
- When BLANK_CYC=0, `an` changes directly from one digit to the next.
- **Load latency.** From `load` to visible nibbles: up to 4·TICK_DIV+1 cycles, because visibility waits for the next wrap.
- **Disabling (`en` 1→0).** `an` becomes 4'hF on the next edge. `sel`, `cnt`, `disp` and `pend` all hold. `frame_done` is 0 and `load` is still accepted.
- **Re-enabling.** Scanning resumes from the held `cnt` and `sel`.
- **Reset mid-frame.** The asynchronous assert immediately forces the reset values. A pending word is discarded.
- Reset deassertion is assumed to be synchronised externally.

## Structure
- **Shared package `seg_pkg`:**
  - constants NUM_DIGITS=4, SEL_W=2, NIB_W=4, WORD_W=16;
  - function `an_decode(sel)` returning the active-low one-hot anode pattern;
  - typedef `nibble_t` = logic[3:0].
- **Sub-module `seg_prescaler`:** parameter TICK_DIV; ports clk, rst_n, en, cnt, tick. It is reused by the blink logic downstream.
- The top level holds the digit counter, the pend/disp registers, the leading-zero logic and the anode/frame registers.

## Test plan
Bench parameters: TICK_DIV=8, BLANK_CYC=2.
- **Reset and scan.** Reset, then `en`=1. Required: `sel` sequence 0,1,2,3,0 changing every 8 cycles. `an` = F,F,E,E,E,E,E,E for slot 0 and F,F,D,… for slot 1. `frame_done` pulses once every 32 cycles.
- **Frame-synchronous load.** `load` with `data_in`=16'h12A4 while `sel`=1. Required: `d0..d3` stay 0 until the wrap, then read 4,A,2,1 on the cycle `sel` becomes 0.
- **Load on wrap cycle.** `load` 16'h5555 on the wrap-tick cycle while `pend`=16'h1111 is pending. Required: `disp`=16'h1111 this frame and 16'h5555 after the next wrap.
- **Leading-zero suppression.** `lz_en`=1, `disp`=16'h0030. Required: `an` stays F during slots 2 and 3, shows D in slot 1 and E in slot 0. `disp`=16'h0000 shows digit 0 only.
- **Enable low mid-slot.** Drop `en` at `cnt`=5 with `sel`=2 and hold 20 cycles. Required: `an`=F, `sel`=2 and `cnt`=5 held. Re-enable: a tick occurs 3 cycles later and `sel`=3.
- **Reset mid-frame.** Assert `rst_n`=0 at `sel`=3 with `pend_v`=1. Required: asynchronous return to `an`=F, `sel`=0, `d0..d3`=0, and the pending word is never displayed.
